// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: status encoding, seconds limit, count direction and seconds clamp shared by the lap timer
package stopwatch_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    EXPIRED = 2'b11
  } status_t;
  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  function automatic logic [5:0] clamp_sec(input logic [5:0] s);
    return s > SEC_MAX ? SEC_MAX : s;
  endfunction
endpackage

// File: rtl/lap_fifo.sv
// lap_fifo: lap capture FIFO (clk, rst_n, clr flush, push/din write, valid/ready/dout head read, ovf sticky drop flag)
module lap_fifo #(
  parameter int W = 14,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         ovf
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] cnt;
  logic pop, wr_en, full;
  assign valid = cnt != '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign pop = valid && ready;
  assign wr_en = push && (!full || pop);
  assign dout = mem[rd];
  always_ff @(posedge clk)
    if (wr_en) mem[wr] <= din;
  always_ff @(posedge clk)
    if (!rst_n || clr) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      rd <= rd + AW'(pop);
      wr <= wr + AW'(wr_en);
      cnt <= cnt + (AW+1)'(wr_en) - (AW+1)'(pop);
      ovf <= ovf || (push && !wr_en);
    end
endmodule

// File: rtl/lap_timer.sv
// lap_timer: up/down min:sec stopwatch (clk, rst_n; start/stop/clear/load/lap commands; minutes/seconds/status/done; lap FIFO read port)
module lap_timer
  import stopwatch_pkg::*;
#(
  parameter int MIN_W = 8,
  parameter int PRESCALE = 1,
  parameter int LAP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             load,
  input  logic             load_dir,
  input  logic [MIN_W-1:0] load_min,
  input  logic [5:0]       load_sec,
  input  logic             lap,
  output logic [MIN_W-1:0] minutes,
  output logic [5:0]       seconds,
  output logic [1:0]       status,
  output logic             done,
  output logic             lap_valid,
  input  logic             lap_ready,
  output logic [MIN_W-1:0] lap_min,
  output logic [5:0]       lap_sec,
  output logic             lap_ovf
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  status_t state, state_n;
  logic [MIN_W-1:0] min_q, min_n;
  logic [5:0] sec_q, sec_n;
  logic dir_q, dir_n;
  logic [PW-1:0] presc_q, presc_n;
  logic tick, at_max, at_zero, hits_end, push;
  logic [MIN_W+5:0] head;
  assign tick = state == RUNNING && presc_q == PW'(PRESCALE - 1);
  assign at_max = &min_q && sec_q == SEC_MAX;
  assign at_zero = min_q == '0 && sec_q == '0;
  assign hits_end = dir_q == DIR_DOWN ? min_q == '0 && sec_q <= 6'd1 : at_max;
  assign presc_n = state == RUNNING ? (tick ? '0 : presc_q + PW'(1)) : state == PAUSED ? presc_q : '0;
  always_comb begin
    state_n = state;
    dir_n = dir_q;
    min_n = min_q;
    sec_n = sec_q;
    if (tick && !(dir_q == DIR_DOWN ? at_zero : at_max)) begin
      min_n = dir_q == DIR_DOWN ? min_q - MIN_W'(sec_q == '0) : min_q + MIN_W'(sec_q == SEC_MAX);
      sec_n = dir_q == DIR_DOWN ? (sec_q == '0 ? SEC_MAX : sec_q - 6'd1) : (sec_q == SEC_MAX ? 6'd0 : sec_q + 6'd1);
    end
    if (clear) begin
      state_n = IDLE;
      dir_n = DIR_UP;
      min_n = '0;
      sec_n = '0;
    end else if (state == IDLE) begin
      if (load) begin
        min_n = load_min;
        sec_n = clamp_sec(load_sec);
        dir_n = load_dir;
      end else if (start) state_n = dir_q == DIR_DOWN && at_zero ? EXPIRED : RUNNING;
    end else if (state == RUNNING) state_n = tick && hits_end ? EXPIRED : stop ? PAUSED : RUNNING;
    else if (state == PAUSED && start && !stop) state_n = RUNNING;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      min_q <= '0;
      sec_q <= '0;
      dir_q <= DIR_UP;
      presc_q <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      min_q <= min_n;
      sec_q <= sec_n;
      dir_q <= dir_n;
      presc_q <= presc_n;
      done <= state_n == EXPIRED && state != EXPIRED;
    end
  assign status = state;
  assign minutes = min_q;
  assign seconds = sec_q;
  assign push = lap && !clear && (state == RUNNING || state == PAUSED);
  assign {lap_min, lap_sec} = head;
  lap_fifo #(.W(MIN_W + 6), .DEPTH(LAP_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clear),
    .push(push),
    .din({min_q, sec_q}),
    .ready(lap_ready),
    .valid(lap_valid),
    .dout(head),
    .ovf(lap_ovf)
  );
endmodule

// File: tb/tb_lap_timer.sv
// tb_lap_timer: two lap_timer configurations against a total-seconds reference model, directed scenarios then random commands
module tb_lap_timer;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic clear = 1'b0;
  logic load = 1'b0;
  logic load_dir = 1'b0;
  logic lap = 1'b0;
  logic lap_ready = 1'b0;
  logic [7:0] load_min = '0;
  logic [5:0] load_sec = '0;
  logic [7:0] minutes0, lap_min0;
  logic [5:0] seconds0, lap_sec0, seconds1, lap_sec1;
  logic [1:0] status0, status1, minutes1, lap_min1;
  logic done0, lap_valid0, lap_ovf0, done1, lap_valid1, lap_ovf1;
  int checks = 0;
  int errors = 0;
  int MW [2] = '{8, 2};
  int PS [2] = '{1, 4};
  int m_st [2];
  int m_t [2];
  int m_dir [2];
  int m_pc [2];
  int m_ovf [2];
  int m_done [2];
  int q [2][$];
  always #5 clk = ~clk;
  lap_timer #(.MIN_W(8), .PRESCALE(1), .LAP_DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .load(load),
    .load_dir(load_dir), .load_min(load_min), .load_sec(load_sec), .lap(lap),
    .minutes(minutes0), .seconds(seconds0), .status(status0), .done(done0),
    .lap_valid(lap_valid0), .lap_ready(lap_ready), .lap_min(lap_min0), .lap_sec(lap_sec0), .lap_ovf(lap_ovf0)
  );
  lap_timer #(.MIN_W(2), .PRESCALE(4), .LAP_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .load(load),
    .load_dir(load_dir), .load_min(load_min[1:0]), .load_sec(load_sec), .lap(lap),
    .minutes(minutes1), .seconds(seconds1), .status(status1), .done(done1),
    .lap_valid(lap_valid1), .lap_ready(lap_ready), .lap_min(lap_min1), .lap_sec(lap_sec1), .lap_ovf(lap_ovf1)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int tm0();
    return int'(minutes0) * 60 + int'(seconds0);
  endfunction
  function automatic int tm1();
    return int'(minutes1) * 60 + int'(seconds1);
  endfunction
  task automatic model_reset(input int i);
    m_st[i] = 0;
    m_t[i] = 0;
    m_dir[i] = 0;
    m_pc[i] = 0;
    m_ovf[i] = 0;
    m_done[i] = 0;
    q[i].delete();
  endtask
  task automatic model_step(input int i);
    int ns, nt, nd, maxt;
    bit tick, expd, push, pop;
    maxt = ((1 << MW[i]) - 1) * 60 + 59;
    ns = m_st[i];
    nt = m_t[i];
    nd = m_dir[i];
    expd = 0;
    tick = m_st[i] == 1 && m_pc[i] == PS[i] - 1;
    m_pc[i] = m_st[i] == 1 ? (m_pc[i] + 1) % PS[i] : m_st[i] == 2 ? m_pc[i] : 0;
    if (tick) begin
      if (m_dir[i] == 0) begin
        if (m_t[i] == maxt) expd = 1;
        else nt = m_t[i] + 1;
      end else if (m_t[i] <= 1) begin
        nt = 0;
        expd = 1;
      end else nt = m_t[i] - 1;
    end
    push = lap && (m_st[i] == 1 || m_st[i] == 2);
    pop = lap_ready && q[i].size() > 0;
    if (clear) begin
      q[i].delete();
      m_ovf[i] = 0;
    end else begin
      if (pop) void'(q[i].pop_front());
      if (push) begin
        if (q[i].size() < DEPTH) q[i].push_back(m_t[i]);
        else m_ovf[i] = 1;
      end
    end
    if (clear) begin
      ns = 0;
      nt = 0;
      nd = 0;
    end else if (m_st[i] == 0) begin
      if (load) begin
        nt = (int'(load_min) % (1 << MW[i])) * 60 + (load_sec > 6'd59 ? 59 : int'(load_sec));
        nd = int'(load_dir);
      end else if (start) ns = (m_dir[i] == 1 && m_t[i] == 0) ? 3 : 1;
    end else if (m_st[i] == 1) ns = expd ? 3 : stop ? 2 : 1;
    else if (m_st[i] == 2 && start && !stop) ns = 1;
    m_done[i] = (ns == 3 && m_st[i] != 3) ? 1 : 0;
    m_st[i] = ns;
    m_t[i] = nt;
    m_dir[i] = nd;
  endtask
  task automatic cmp(input int i, input int mn, input int sc, input int st, input int dn,
                     input int lv, input int lm, input int ls, input int ov);
    check($sformatf("u%0d minutes", i), mn, m_t[i] / 60);
    check($sformatf("u%0d seconds", i), sc, m_t[i] % 60);
    check($sformatf("u%0d status", i), st, m_st[i]);
    check($sformatf("u%0d done", i), dn, m_done[i]);
    check($sformatf("u%0d lap_valid", i), lv, q[i].size() > 0 ? 1 : 0);
    check($sformatf("u%0d lap_ovf", i), ov, m_ovf[i]);
    if (q[i].size() > 0) begin
      check($sformatf("u%0d lap_min", i), lm, q[i][0] / 60);
      check($sformatf("u%0d lap_sec", i), ls, q[i][0] % 60);
    end
  endtask
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++)
      if (!rst_n) model_reset(i);
      else model_step(i);
    @(negedge clk);
    cmp(0, int'(minutes0), int'(seconds0), int'(status0), int'(done0), int'(lap_valid0), int'(lap_min0), int'(lap_sec0), int'(lap_ovf0));
    cmp(1, int'(minutes1), int'(seconds1), int'(status1), int'(done1), int'(lap_valid1), int'(lap_min1), int'(lap_sec1), int'(lap_ovf1));
  endtask
  task automatic do_load(input int mn, input int sc, input logic dir);
    load = 1'b1;
    load_min = 8'(mn);
    load_sec = 6'(sc);
    load_dir = dir;
    step();
    load = 1'b0;
  endtask
  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 2; i++) model_reset(i);
    step();
    step();
    check("reset status", int'(status0), 0);
    check("reset time", tm0(), 0);
    check("reset lap_valid", int'(lap_valid0), 0);
    rst_n = 1'b1;
    do_load(0, 58, 1'b0);
    do_start();
    step();
    check("up 0:59", tm0(), 59);
    step();
    check("up 1:00", tm0(), 60);
    step();
    check("up 1:01", tm0(), 61);
    check("up running", int'(status0), 1);
    do_clear();
    do_load(0, 2, 1'b1);
    do_start();
    repeat (3) step();
    check("p4 held 0:02", tm1(), 2);
    step();
    check("p4 0:01", tm1(), 1);
    check("p4 running", int'(status1), 1);
    repeat (3) step();
    check("p4 no early done", int'(done1), 0);
    step();
    check("p4 0:00", tm1(), 0);
    check("p4 expired", int'(status1), 3);
    check("p4 done", int'(done1), 1);
    step();
    check("p4 done one cycle", int'(done1), 0);
    check("p4 stays expired", int'(status1), 3);
    do_clear();
    do_load(3, 58, 1'b0);
    do_start();
    repeat (4) step();
    check("w2 3:59", tm1(), 239);
    check("w2 running", int'(status1), 1);
    repeat (4) step();
    check("w2 expired", int'(status1), 3);
    check("w2 held 3:59", tm1(), 239);
    check("w2 done", int'(done1), 1);
    do_clear();
    do_start();
    lap_ready = 1'b0;
    lap = 1'b1;
    repeat (5) step();
    lap = 1'b0;
    check("fifo ovf", int'(lap_ovf0), 1);
    check("fifo valid", int'(lap_valid0), 1);
    step();
    step();
    check("fifo head stable", int'(lap_sec0), 0);
    lap_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("fifo order valid", int'(lap_valid0), 1);
      check("fifo order sec", int'(lap_sec0), k);
      step();
    end
    lap_ready = 1'b0;
    check("fifo drained", int'(lap_valid0), 0);
    stop = 1'b1;
    start = 1'b1;
    step();
    stop = 1'b0;
    start = 1'b0;
    check("stop beats start", int'(status0), 2);
    clear = 1'b1;
    do_load(5, 30, 1'b0);
    clear = 1'b0;
    check("clear beats load status", int'(status0), 0);
    check("clear beats load time", tm0(), 0);
    do_load(0, 63, 1'b0);
    check("load clamp", tm0(), 59);
    do_start();
    lap = 1'b1;
    repeat (5) step();
    lap = 1'b0;
    check("pre-reset ovf", int'(lap_ovf0), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid reset status", int'(status0), 0);
    check("mid reset time", tm0(), 0);
    check("mid reset lap_valid", int'(lap_valid0), 0);
    check("mid reset lap_ovf", int'(lap_ovf0), 0);
    check("mid reset done", int'(done0), 0);
    for (int n = 0; n < 3000; n++) begin
      rst_n = $urandom_range(199) != 0;
      clear = $urandom_range(59) == 0;
      load = m_st[0] == 0 && $urandom_range(4) == 0;
      start = $urandom_range(4) == 0;
      stop = m_st[0] != 0 && $urandom_range(11) == 0;
      lap = $urandom_range(2) == 0;
      lap_ready = 1'($urandom_range(1));
      load_dir = 1'($urandom_range(1));
      load_min = $urandom_range(3) == 0 ? 8'(255 - $urandom_range(1)) : 8'($urandom_range(3));
      load_sec = 6'($urandom_range(63));
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
